// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the RPN calculator and its host-side program loader:
// default instruction/address widths, the halt encoding, the opcode constants
// the calculator understands, and the loader state encoding.
// -----------------------------------------------------------------------------
package calc_pkg;

    // Default instruction/data width and code-memory address width.
    localparam int CALC_N = 16;
    localparam int CALC_M = 10;

    // Top two bits of an instruction word select its class.
    localparam logic [1:0] OP_PUSH     = 2'b00;   // low N-2 bits are a literal
    localparam logic [1:0] OP_RSVD     = 2'b01;
    localparam logic [1:0] OP_ALU      = 2'b10;   // low nibble selects the ALU op
    localparam logic [1:0] HALT_PREFIX = 2'b11;   // stop execution

    // ALU operation codes carried in the low nibble of an OP_ALU word.
    localparam logic [3:0] ALU_NOP = 4'h0;
    localparam logic [3:0] ALU_DUP = 4'h1;
    localparam logic [3:0] ALU_ADD = 4'h2;
    localparam logic [3:0] ALU_SUB = 4'h3;
    localparam logic [3:0] ALU_MUL = 4'h4;

    // Canonical halt word at the default width.
    localparam logic [CALC_N-1:0] HALT_WORD = {HALT_PREFIX, {(CALC_N-2){1'b0}}};

    // Loader states.
    typedef enum logic [2:0] {
        RX   = 3'd0,
        WR   = 3'd1,
        GO   = 3'd2,
        WAIT = 3'd3,
        OUT  = 3'd4
    } state_e;

    // True when the class bits of a word mark it as a halt.
    function automatic logic is_halt_prefix(input logic [1:0] cls);
        return (cls == HALT_PREFIX);
    endfunction

endpackage

// File: rtl/byte_packer.sv
// -----------------------------------------------------------------------------
// byte_packer
// Collects N/8 bytes MSB-first into an N-bit word.
// Ports:
//   clk, nrst   clock and asynchronous active-low reset
//   byte_in     incoming byte
//   byte_en     byte is transferred this cycle
//   word        assembled word (valid in the cycle after word_done)
//   word_done   the byte transferred this cycle completes a word
// -----------------------------------------------------------------------------
module byte_packer import calc_pkg::*; #(
    parameter int N = CALC_N
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic [7:0]   byte_in,
    input  logic         byte_en,
    output logic [N-1:0] word,
    output logic         word_done
);

    localparam int NB = N / 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);

    logic [N-1:0]  word_q, word_d;
    logic [CW-1:0] cnt_q,  cnt_d;

    // Shift each accepted byte in from the right; strobe when the word fills.
    always_comb begin
        word_d    = word_q;
        cnt_d     = cnt_q;
        word_done = 1'b0;
        if (byte_en) begin
            word_d = {word_q[N-9:0], byte_in};
            if (cnt_q == CNT_LAST) begin
                cnt_d     = '0;
                word_done = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            word_d = word_q;
        end
    end

    // Word and byte-counter registers; reset drops any partial word.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word = word_q;

endmodule

// File: rtl/calc_prog_loader.sv
// -----------------------------------------------------------------------------
// calc_prog_loader
// Receives a program as a byte stream, packs it into N-bit words, writes them
// into the steering block's code memory, starts the steering block and hands
// its top-of-stack result to the host.
// Ports:
//   clk, nrst                 clock, asynchronous active-low reset
//   in_data/in_valid/in_ready program byte stream (MSB-first words)
//   datain/addr/wr            code-memory write port
//   start                     one-cycle run request
//   ready/result              steering block idle flag and top of stack
//   res/res_err               captured result and truncation flag
//   res_valid/res_ready       result handshake towards the host
// -----------------------------------------------------------------------------
module calc_prog_loader import calc_pkg::*; #(
    parameter int N = CALC_N,
    parameter int M = CALC_M
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] datain,
    output logic [M-1:0] addr,
    output logic         wr,
    output logic         start,
    input  logic         ready,
    input  logic [N-1:0] result,
    output logic [N-1:0] res,
    output logic         res_err,
    output logic         res_valid,
    input  logic         res_ready
);

    localparam logic [N-1:0] HALT_W   = {HALT_PREFIX, {(N-2){1'b0}}};
    localparam logic [M-1:0] ADDR_MAX = {M{1'b1}};

    state_e       state_q, state_d;
    logic [M-1:0] addr_q, addr_d;
    logic [N-1:0] res_q, res_d;
    logic         res_err_q, res_err_d;

    logic         byte_en_s;
    logic         word_done_s;
    logic [N-1:0] word_s;
    logic         halt_s;
    logic         ovf_s;

    // Bytes are only taken while receiving; in_ready itself depends on state only.
    assign byte_en_s = in_valid && (state_q == RX);

    byte_packer #(.N(N)) u_packer (
        .clk       (clk),
        .nrst      (nrst),
        .byte_in   (in_data),
        .byte_en   (byte_en_s),
        .word      (word_s),
        .word_done (word_done_s)
    );

    // A non-halt word landing in the last code slot is replaced by a halt so
    // the program always terminates and the address never wraps.
    assign halt_s = is_halt_prefix(word_s[N-1:N-2]);
    assign ovf_s  = !halt_s && (addr_q == ADDR_MAX);

    // Next-state, address, result and error-flag logic.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        res_d     = res_q;
        res_err_d = res_err_q;
        case (state_q)
            RX: begin
                if (word_done_s) begin
                    state_d = WR;
                end else begin
                    state_d = RX;
                end
            end
            WR: begin
                if (halt_s) begin
                    state_d = GO;
                end else if (ovf_s) begin
                    res_err_d = 1'b1;
                    state_d   = GO;
                end else begin
                    addr_d  = addr_q + M'(1);
                    state_d = RX;
                end
            end
            GO: begin
                state_d = WAIT;
            end
            WAIT: begin
                // The steering block is already busy in the first WAIT cycle,
                // so the first ready seen here marks the end of the run.
                if (ready) begin
                    res_d   = result;
                    state_d = OUT;
                end else begin
                    state_d = WAIT;
                end
            end
            OUT: begin
                if (res_ready) begin
                    addr_d    = '0;
                    res_err_d = 1'b0;
                    state_d   = RX;
                end else begin
                    state_d = OUT;
                end
            end
            default: begin
                state_d = RX;
            end
        endcase
    end

    // State, address, result and error registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= RX;
            addr_q    <= '0;
            res_q     <= '0;
            res_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            res_q     <= res_d;
            res_err_q <= res_err_d;
        end
    end

    // Outputs come from registers or a decode of the state register only.
    assign in_ready  = (state_q == RX);
    assign wr        = (state_q == WR);
    assign start     = (state_q == GO);
    assign res_valid = (state_q == OUT);
    assign datain    = ovf_s ? HALT_W : word_s;
    assign addr      = addr_q;
    assign res       = res_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_calc_prog_loader.sv
module tb_calc_prog_loader;
    import calc_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       nrst;
    logic       sel;
    logic [7:0] in_data;
    logic       in_valid;
    logic       res_ready;

    logic        in_valid_a, res_ready_a, in_ready_a, wr_a, start_a, res_err_a, res_valid_a;
    logic [15:0] datain_a, res_a;
    logic [9:0]  addr_a;
    logic        in_valid_b, res_ready_b, in_ready_b, wr_b, start_b, res_err_b, res_valid_b;
    logic [15:0] datain_b, res_b;
    logic [1:0]  addr_b;

    logic        ready_m;
    logic [15:0] result_m;

    assign in_valid_a  = sel ? 1'b0 : in_valid;
    assign res_ready_a = sel ? 1'b0 : res_ready;
    assign in_valid_b  = sel ? in_valid : 1'b0;
    assign res_ready_b = sel ? res_ready : 1'b0;

    calc_prog_loader #(.N(16), .M(10)) dut_a (
        .clk(clk), .nrst(nrst), .in_data(in_data), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .datain(datain_a), .addr(addr_a), .wr(wr_a), .start(start_a), .ready(ready_m),
        .result(result_m), .res(res_a), .res_err(res_err_a), .res_valid(res_valid_a),
        .res_ready(res_ready_a)
    );

    calc_prog_loader #(.N(16), .M(2)) dut_b (
        .clk(clk), .nrst(nrst), .in_data(in_data), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .datain(datain_b), .addr(addr_b), .wr(wr_b), .start(start_b), .ready(ready_m),
        .result(result_m), .res(res_b), .res_err(res_err_b), .res_valid(res_valid_b),
        .res_ready(res_ready_b)
    );

    // View of whichever loader is selected
    logic        m_in_ready, m_wr, m_start, m_res_err, m_res_valid;
    logic [15:0] m_datain, m_res;
    logic [9:0]  m_addr;
    assign m_in_ready  = sel ? in_ready_b  : in_ready_a;
    assign m_wr        = sel ? wr_b        : wr_a;
    assign m_start     = sel ? start_b     : start_a;
    assign m_res_err   = sel ? res_err_b   : res_err_a;
    assign m_res_valid = sel ? res_valid_b : res_valid_a;
    assign m_datain    = sel ? datain_b    : datain_a;
    assign m_res       = sel ? res_b       : res_a;
    assign m_addr      = sel ? {8'd0, addr_b} : addr_a;

    // ---------------- counters and compare helper ----------------
    int pass_cnt = 0;
    int chk_cnt  = 0;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endfunction

    // ---------------- steering block / calculator model ----------------
    logic [15:0] mem [0:1023];
    int          busy_m;

    function automatic void eval_prog(output logic [15:0] top, output int n);
        logic [15:0] stk [0:63];
        logic [15:0] w;
        int sp;
        sp  = 0;
        n   = 0;
        top = 16'd0;
        for (int i = 0; i < 1024; i++) begin
            w = mem[i];
            n++;
            if (w[15:14] == 2'b11) break;
            else if (w[15:14] == 2'b00) begin
                if (sp < 64) begin stk[sp] = w; sp++; end
            end else if (w[15:14] == 2'b10 && sp >= 2) begin
                if (w[3:0] == 4'h2) stk[sp-2] = stk[sp-2] + stk[sp-1];
                else if (w[3:0] == 4'h3) stk[sp-2] = stk[sp-2] - stk[sp-1];
                sp--;
            end
        end
        if (sp > 0) top = stk[sp-1];
    endfunction

    always @(posedge clk or negedge nrst) begin
        logic [15:0] t;
        int          n;
        if (!nrst) begin
            ready_m  <= 1'b1;
            busy_m   <= 0;
            result_m <= 16'd0;
        end else begin
            if (m_wr) mem[m_addr] <= m_datain;
            if (m_start) begin
                eval_prog(t, n);
                result_m <= t;
                busy_m   <= n;
                ready_m  <= 1'b0;
            end else if (busy_m != 0) begin
                busy_m <= busy_m - 1;
                if (busy_m == 1) ready_m <= 1'b1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct { logic [9:0] a; logic [15:0] d; } wr_t;
    typedef struct { logic [15:0] r; logic e; } res_t;
    wr_t  exp_wr[$];
    res_t exp_res[$];
    int   lat_exp = 0;

    int          neg_cyc = 0;
    int          acc_cyc = 0;
    logic        prev_rv = 1'b0, start_prev = 1'b0, in_wait = 1'b0, last_halt = 1'b0;
    logic [15:0] hold_res;
    logic        hold_err;

    // Monitor: samples on the falling edge, pops expectations on DUT events
    always @(negedge clk) begin
        wr_t  ew;
        res_t er;
        if (!nrst) begin
            in_wait = 1'b0; prev_rv = 1'b0; start_prev = 1'b0; last_halt = 1'b0;
        end else begin
            if (m_wr) begin
                if (exp_wr.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL wr_unexpected: got addr %0h data %0h expected no write", m_addr, m_datain);
                end else begin
                    ew = exp_wr.pop_front();
                    check("wr_addr", m_addr, ew.a);
                    check("wr_data", m_datain, ew.d);
                end
                check("wr_with_start", m_start, 1'b0);
                check("wr_in_wait", in_wait, 1'b0);
                last_halt = (m_datain[15:14] == 2'b11);
            end
            if (m_start) begin
                check("start_after_halt", last_halt, 1'b1);
                check("start_one_cycle", start_prev, 1'b0);
                in_wait = 1'b1;
                last_halt = 1'b0;
            end
            if (m_res_valid && !prev_rv) begin
                in_wait  = 1'b0;
                hold_res = m_res;
                hold_err = m_res_err;
                if (lat_exp != 0) begin
                    check("latency", neg_cyc - acc_cyc, lat_exp);
                    lat_exp = 0;
                end
            end
            if (m_res_valid && prev_rv) begin
                check("res_stable", m_res, hold_res);
                check("res_err_stable", m_res_err, hold_err);
                check("in_ready_in_out", m_in_ready, 1'b0);
            end
            if (m_res_valid && res_ready) begin
                if (exp_res.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL res_unexpected: got res %0h expected no result", m_res);
                end else begin
                    er = exp_res.pop_front();
                    check("res", m_res, er.r);
                    check("res_err", m_res_err, er.e);
                end
            end
            if (in_valid && m_in_ready) acc_cyc = neg_cyc;
            prev_rv    = m_res_valid;
            start_prev = m_start;
        end
        neg_cyc++;
    end

    // ---------------- stimulus ----------------
    logic [7:0] prog[$];

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int n;
        bit acc;
        n = 0; acc = 1'b0;
        while (!acc && n < 200) begin
            in_data  = b;
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            acc      = in_valid && m_in_ready;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        check("byte_accepted", acc, 1'b1);
    endtask

    task automatic finish_prog(input int hold);
        int n;
        n = 0;
        while (!m_res_valid && n < 100) begin @(posedge clk); #1; n++; end
        check("res_valid_seen", m_res_valid, 1'b1);
        repeat (hold) @(posedge clk);
        #1;
        res_ready = 1'b1;
        n = 0;
        while (m_res_valid && n < 5) begin @(posedge clk); #1; n++; end
        check("res_valid_released", m_res_valid, 1'b0);
    endtask

    task automatic run_prog(input bit rnd, input int hold);
        res_ready = (hold == 0);
        foreach (prog[i]) send_byte(prog[i], rnd);
        finish_prog(hold);
    endtask

    task automatic push_wr(input logic [9:0] a, input logic [15:0] d);
        exp_wr.push_back('{a: a, d: d});
    endtask

    task automatic push_res(input logic [15:0] r, input logic e);
        exp_res.push_back('{r: r, e: e});
    endtask

    task automatic reset_check(input string tag);
        nrst = 1'b0;
        #2;
        check({tag, "_in_ready"}, m_in_ready, 1'b1);
        check({tag, "_wr"}, m_wr, 1'b0);
        check({tag, "_start"}, m_start, 1'b0);
        check({tag, "_res_valid"}, m_res_valid, 1'b0);
        check({tag, "_res"}, m_res, 16'd0);
        check({tag, "_res_err"}, m_res_err, 1'b0);
        exp_wr.delete();
        exp_res.delete();
        lat_exp  = 0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 nrst = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sel = 1'b0; in_data = 8'd0; in_valid = 1'b0; res_ready = 1'b1;
        nrst = 1'b1;
        #1;
        reset_check("por");

        // Basic program: 3 + 4
        push_wr(10'd0, 16'h0003); push_wr(10'd1, 16'h0004);
        push_wr(10'd2, 16'h8002); push_wr(10'd3, 16'hC000);
        push_res(16'd7, 1'b0);
        prog = {8'h00, 8'h03, 8'h00, 8'h04, 8'h80, 8'h02, 8'hC0, 8'h00};
        run_prog(1'b0, 0);

        // Halt only, minimal latency
        push_wr(10'd0, 16'hC000);
        push_res(16'd0, 1'b0);
        lat_exp = 5;
        prog = {8'hC0, 8'h00};
        run_prog(1'b0, 0);
        check("latency_checked", lat_exp, 0);

        // Random in_valid, result held 10 cycles
        push_wr(10'd0, 16'h0003); push_wr(10'd1, 16'h0004);
        push_wr(10'd2, 16'h8002); push_wr(10'd3, 16'hC000);
        push_res(16'd7, 1'b0);
        prog = {8'h00, 8'h03, 8'h00, 8'h04, 8'h80, 8'h02, 8'hC0, 8'h00};
        run_prog(1'b1, 10);

        // Back-to-back programs
        push_wr(10'd0, 16'h0005); push_wr(10'd1, 16'hC000); push_res(16'd5, 1'b0);
        prog = {8'h00, 8'h05, 8'hC0, 8'h00};
        run_prog(1'b0, 0);
        push_wr(10'd0, 16'h0009); push_wr(10'd1, 16'hC000); push_res(16'd9, 1'b0);
        prog = {8'h00, 8'h09, 8'hC0, 8'h00};
        run_prog(1'b0, 0);

        // Reset during WAIT
        push_wr(10'd0, 16'h0006); push_wr(10'd1, 16'hC000); push_res(16'd6, 1'b0);
        res_ready = 1'b1;
        prog = {8'h00, 8'h06, 8'hC0, 8'h00};
        foreach (prog[i]) send_byte(prog[i], 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("in_wait_before_reset", in_wait, 1'b1);
        reset_check("rst_wait");

        // Reset after the first byte of a word
        send_byte(8'h00, 1'b0);
        reset_check("rst_mid");
        push_wr(10'd0, 16'h0008); push_wr(10'd1, 16'hC000); push_res(16'd8, 1'b0);
        prog = {8'h00, 8'h08, 8'hC0, 8'h00};
        run_prog(1'b0, 0);

        // Overflow on the small-address loader
        sel = 1'b1;
        @(posedge clk); #1;
        push_wr(10'd0, 16'h0001); push_wr(10'd1, 16'h0001);
        push_wr(10'd2, 16'h0001); push_wr(10'd3, 16'hC000);
        push_res(16'd1, 1'b1);
        prog = {8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h01};
        run_prog(1'b0, 0);
        check("res_err_cleared", m_res_err, 1'b0);
        push_wr(10'd0, 16'hC000); push_res(16'd0, 1'b0);
        prog = {8'hC0, 8'h00};
        run_prog(1'b0, 0);

        repeat (3) @(posedge clk);
        #1;
        check("wr_queue_empty", exp_wr.size(), 0);
        check("res_queue_empty", exp_res.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
